// File: rtl/puf_seq_pkg.sv
// ============================================================================
//  Module      : puf_seq_pkg
//  Description : Shared constants, FSM encoding and sizing helpers for the
//                PUF challenge sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package puf_seq_pkg;

    localparam int SEG_W = 64;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] S_ARM     = 3'd1;
    localparam logic [ST_W-1:0] S_FIRE    = 3'd2;
    localparam logic [ST_W-1:0] S_SAMPLE  = 3'd3;
    localparam logic [ST_W-1:0] S_RELEASE = 3'd4;
    localparam logic [ST_W-1:0] S_DONE    = 3'd5;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Index width for v entries, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/puf_sync2.sv
// ============================================================================
//  Module      : puf_sync2
//  Description : Two-flop synchroniser for a single asynchronous bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/puf_chal_seq_ctrl.sv
// ============================================================================
//  Module      : puf_chal_seq_ctrl
//  Description : Challenge assembly and trigger/measure sequencer for an
//                arbiter/iXOR PUF core. Define PUF_MAJ_VOTE_EN to enable
//                REPS-pass per-bit majority voting of the response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_chal_seq_ctrl
    import puf_seq_pkg::*;
#(
    parameter int CHAL_W      = 64,
    parameter int RESP_W      = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int REPS        = 5
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             chal_en,
    input  logic                                             seg_wr,
    input  logic [clog2_min1(ceil_div(CHAL_W, SEG_W))-1:0]   seg_id,
    input  logic [SEG_W-1:0]                                 seg_data,
    input  logic                                             start,
    input  logic                                             puf_ready,
    input  logic [RESP_W-1:0]                                puf_resp,
    output logic [CHAL_W-1:0]                                challenge,
    output logic                                             tig_t,
    output logic                                             tig_b,
    output logic                                             busy,
    output logic                                             done,
    output logic [RESP_W-1:0]                                resp,
    output logic                                             timeout
);

    localparam int c_NSEG     = ceil_div(CHAL_W, SEG_W);
    localparam int c_SEG_ID_W = clog2_min1(c_NSEG);
    localparam int c_CNT_MAX  = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST     = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_stateNxt;
    logic               w_toHit;
    logic [c_CNT_W-1:0] r_cnt;
    logic [CHAL_W-1:0]  r_chal;
    logic [CHAL_W-1:0]  w_chalNxt;
    logic               w_wrEn;
    logic               w_rdyS;
    logic [RESP_W-1:0]  r_respD1;
    logic [RESP_W-1:0]  r_respD2;
    logic [RESP_W-1:0]  w_respFinal;
    logic               w_lastPass;
    logic               w_start;
    logic               r_tig;
    logic               r_busy;
    logic               r_done;
    logic [RESP_W-1:0]  r_resp;
    logic               r_timeout;
    logic               w_unused_seg;

    puf_sync2 u_rdySync (
        .clk (clk),
        .rst (rst),
        .d   (puf_ready),
        .q   (w_rdyS)
    );

    assign w_wrEn       = seg_wr && chal_en && (r_state == S_IDLE);
    assign w_start      = (r_state == S_IDLE) && (w_stateNxt == S_ARM);
    assign w_unused_seg = ^seg_data;

    // The final segment may be partial: only its low bits reach the register.
    generate
        for (genvar s = 0; s < c_NSEG; s++) begin : g_seg
            localparam int c_LO = s * SEG_W;
            localparam int c_HI = (c_LO + SEG_W > CHAL_W) ? CHAL_W - 1 : c_LO + SEG_W - 1;
            assign w_chalNxt[c_HI:c_LO] = (w_wrEn && (seg_id == c_SEG_ID_W'(s)))
                                          ? seg_data[c_HI-c_LO:0] : r_chal[c_HI:c_LO];
        end
    endgenerate

`ifdef PUF_MAJ_VOTE_EN
    localparam int c_VOTE_W = $clog2(REPS + 1);

    logic [RESP_W-1:0][c_VOTE_W-1:0] r_vote;
    logic [c_VOTE_W-1:0]             r_rep;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_vote <= '0;
            r_rep  <= '0;
        end else begin
            if (r_state == S_SAMPLE) begin
                for (int i = 0; i < RESP_W; i++) begin
                    r_vote[i] <= r_vote[i] + c_VOTE_W'(r_respD2[i]);
                end
            end
            if ((r_state == S_RELEASE) && (w_stateNxt == S_ARM)) begin
                r_rep <= r_rep + c_VOTE_W'(1);
            end
        end
    end

    assign w_lastPass = (r_rep == c_VOTE_W'(REPS - 1));

    generate
        for (genvar i = 0; i < RESP_W; i++) begin : g_vote
            assign w_respFinal[i] = (r_vote[i] > c_VOTE_W'(REPS / 2));
        end
    endgenerate
`else
    localparam int c_unused_reps = REPS;

    logic [RESP_W-1:0] r_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_cap <= r_respD2;
        end
    end

    assign w_lastPass  = 1'b1;
    assign w_respFinal = r_cap;
`endif

    always_comb begin
        w_stateNxt = r_state;
        w_toHit    = 1'b0;
        case (r_state)
            S_IDLE:    if (start && chal_en) w_stateNxt = S_ARM;
            S_ARM:     if (r_cnt == c_SETTLE_LAST) w_stateNxt = S_FIRE;
            S_FIRE: begin
                if (w_rdyS) begin
                    w_stateNxt = S_SAMPLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_stateNxt = S_DONE;
                    w_toHit    = 1'b1;
                end
            end
            S_SAMPLE:  w_stateNxt = S_RELEASE;
            S_RELEASE: begin
                if (!w_rdyS) begin
                    w_stateNxt = w_lastPass ? S_DONE : S_ARM;
                end else if (r_cnt == c_TO_LAST) begin
                    w_stateNxt = S_DONE;
                    w_toHit    = 1'b1;
                end
            end
            S_DONE:    w_stateNxt = S_IDLE;
            default:   w_stateNxt = S_IDLE;
        endcase
        if (!chal_en) begin
            w_stateNxt = S_IDLE;
            w_toHit    = 1'b0;
        end
    end

    // Outputs are registered from the next state so the triggers never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_chal    <= '0;
            r_respD1  <= '0;
            r_respD2  <= '0;
            r_tig     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_resp    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state  <= w_stateNxt;
            r_cnt    <= (w_stateNxt != r_state) ? '0 : r_cnt + c_CNT_W'(1);
            r_chal   <= chal_en ? w_chalNxt : '0;
            r_respD1 <= puf_resp;
            r_respD2 <= r_respD1;
            r_tig    <= (w_stateNxt == S_FIRE) || (w_stateNxt == S_SAMPLE);
            r_busy   <= (w_stateNxt == S_ARM) || (w_stateNxt == S_FIRE) ||
                        (w_stateNxt == S_SAMPLE) || (w_stateNxt == S_RELEASE);
            r_done   <= (w_stateNxt == S_DONE);
            if (w_start) begin
                r_timeout <= 1'b0;
            end
            if (w_toHit) begin
                r_resp    <= '0;
                r_timeout <= 1'b1;
            end else if ((r_state == S_RELEASE) && (w_stateNxt == S_DONE)) begin
                r_resp <= w_respFinal;
            end
        end
    end

    assign challenge = r_chal;
    assign tig_t     = r_tig;
    assign tig_b     = r_tig;
    assign busy      = r_busy;
    assign done      = r_done;
    assign resp      = r_resp;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_puf_chal_seq_ctrl.sv
// ============================================================================
//  Module      : tb_puf_chal_seq_ctrl
//  Description : Directed self-checking bench for puf_chal_seq_ctrl; the
//                voting scenario is built when PUF_MAJ_VOTE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_puf_chal_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         chalEn;
    logic         segWr;
    logic [0:0]   segId;
    logic [63:0]  segData;
    logic         start;
    logic         pufReady;
    logic [1:0]   pufResp;
    logic [127:0] challenge;
    logic         tigT, tigB, busy, done, timeout;
    logic [1:0]   resp;

    logic         segWr64;
    logic [0:0]   segId64;
    logic [63:0]  segData64;
    logic         start64;
    logic         pufReady64;
    logic [1:0]   pufResp64;
    logic [63:0]  challenge64;
    logic         tigT64, tigB64, busy64, done64, timeout64;
    logic [1:0]   resp64;

    int checks = 0;
    int errors = 0;
    int tigPulses = 0, tigPulses64 = 0, doneCnt = 0;
    int pulses0, doneBase;
    logic tigQ = 1'b0, tigQ64 = 1'b0;

    always #5 clk = ~clk;

    puf_chal_seq_ctrl #(
        .CHAL_W(128), .RESP_W(2), .SETTLE_CYC(16), .TIMEOUT_CYC(32), .REPS(1)
    ) u_dut (
        .clk(clk), .rst(rst), .chal_en(chalEn), .seg_wr(segWr), .seg_id(segId),
        .seg_data(segData), .start(start), .puf_ready(pufReady), .puf_resp(pufResp),
        .challenge(challenge), .tig_t(tigT), .tig_b(tigB), .busy(busy), .done(done),
        .resp(resp), .timeout(timeout)
    );

    puf_chal_seq_ctrl #(
        .CHAL_W(64), .RESP_W(2), .SETTLE_CYC(16), .TIMEOUT_CYC(1024), .REPS(5)
    ) u_dut64 (
        .clk(clk), .rst(rst), .chal_en(chalEn), .seg_wr(segWr64), .seg_id(segId64),
        .seg_data(segData64), .start(start64), .puf_ready(pufReady64), .puf_resp(pufResp64),
        .challenge(challenge64), .tig_t(tigT64), .tig_b(tigB64), .busy(busy64), .done(done64),
        .resp(resp64), .timeout(timeout64)
    );

    always @(posedge clk) begin
        tigQ   <= tigT;
        tigQ64 <= tigT64;
        if (tigT && !tigQ) tigPulses <= tigPulses + 1;
        if (tigT64 && !tigQ64) tigPulses64 <= tigPulses64 + 1;
        if (done) doneCnt <= doneCnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef PUF_MAJ_VOTE_EN
    task automatic waitTig64(input logic lvl, input string tag);
        int n = 0;
        while (tigT64 !== lvl && n < 60) begin
            step(1);
            n++;
        end
        chk(tag, 128'(tigT64), 128'(lvl));
    endtask
`endif

    initial begin
        rst = 1'b1; chalEn = 1'b0; segWr = 1'b0; segId = '0; segData = '0;
        start = 1'b0; pufReady = 1'b0; pufResp = '0;
        segWr64 = 1'b0; segId64 = '0; segData64 = '0; start64 = 1'b0;
        pufReady64 = 1'b0; pufResp64 = '0;
        step(3);
        chk("rst_chal", challenge, 128'h0);
        chk("rst_tig", {tigT, tigB}, 2'b00);
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_resp", resp, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_chal64", challenge64, 64'h0);
        rst = 1'b0; chalEn = 1'b1;
        step(1);

        // Two-segment challenge assembly
        segWr = 1'b1; segId = 1'b0; segData = 64'h0123_4567_89AB_CDEF;
        step(1);
        chk("t1_seg0", challenge, {64'h0, 64'h0123_4567_89AB_CDEF});
        segId = 1'b1; segData = 64'hFFFF_0000_FFFF_0000;
        step(1);
        segWr = 1'b0;
        chk("t1_full", challenge, 128'hFFFF0000FFFF0000_0123456789ABCDEF);

        // Out-of-range segment on a single-segment build, then clear
        segWr64 = 1'b1; segId64 = 1'b0; segData64 = 64'hDEAD_BEEF_CAFE_F00D;
        step(1);
        segId64 = 1'b1; segData64 = 64'h5555_5555_5555_5555;
        step(1);
        segWr64 = 1'b0;
        chk("t2_seg_oob", challenge64, 64'hDEAD_BEEF_CAFE_F00D);
        chalEn = 1'b0;
        step(1);
        chalEn = 1'b1;
        chk("t2_clear64", challenge64, 64'h0);
        chk("t2_clear128", challenge, 128'h0);

        // Normal measurement with a simultaneous segment write
        segWr = 1'b1; segId = 1'b0; segData = 64'hA5A5_A5A5_A5A5_A5A5; start = 1'b1;
        step(1);
        segWr = 1'b0; start = 1'b0;
        chk("t3_busy", busy, 1'b1);
        chk("t3_chal", challenge, {64'h0, 64'hA5A5_A5A5_A5A5_A5A5});
        step(15);
        chk("t3_tig_pre", tigT, 1'b0);
        step(1);
        chk("t3_tig_fire", {tigT, tigB}, 2'b11);
        step(10);
        pufReady = 1'b1; pufResp = 2'b10;
        step(4);
        chk("t3_tig_release", tigT, 1'b0);
        chk("t3_no_done_yet", done, 1'b0);
        pufReady = 1'b0; pufResp = 2'b00;
        step(3);
        chk("t3_done", done, 1'b1);
        chk("t3_resp", resp, 2'b10);
        chk("t3_timeout", timeout, 1'b0);
        chk("t3_busy_end", busy, 1'b0);
        step(1);
        chk("t3_done_pulse", done, 1'b0);
        chk("t3_resp_hold", resp, 2'b10);

        // Ready never arrives: timeout 32 cycles after FIRE entry
        pulses0 = tigPulses;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(16);
        chk("t4_fire", tigT, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(30);
        chk("t4_pre_done", {done, tigT}, 2'b01);
        step(1);
        chk("t4_done", done, 1'b1);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_resp", resp, 2'b00);
        chk("t4_tig", {tigT, tigB, busy}, 3'b000);
        step(20);
        chk("t4_no_restart", busy, 1'b0);
        chk("t4_pulses", 128'(tigPulses - pulses0), 128'd1);

        // Writes/starts while busy are ignored; chal_en low aborts
        start = 1'b1;
        step(1);
        start = 1'b0;
        segWr = 1'b1; segId = 1'b1; segData = 64'h1111_1111_1111_1111; start = 1'b1;
        step(1);
        segWr = 1'b0; start = 1'b0;
        chk("t5_chal_locked", challenge, {64'h0, 64'hA5A5_A5A5_A5A5_A5A5});
        step(15);
        chk("t5_fire", {tigT, busy}, 2'b11);
        doneBase = doneCnt;
        chalEn = 1'b0;
        step(1);
        chk("t5_abort", {tigT, tigB, busy, done}, 4'b0000);
        chk("t5_abort_chal", challenge, 128'h0);
        chalEn = 1'b1;
        step(30);
        chk("t5_no_done", 128'(doneCnt - doneBase), 128'd0);
        chk("t5_idle", busy, 1'b0);

`ifdef PUF_MAJ_VOTE_EN
        begin
            logic [4:0] pat;
            int n;
            pat = 5'b01101;
            pulses0 = tigPulses64;
            start64 = 1'b1;
            step(1);
            start64 = 1'b0;
            for (int k = 0; k < 5; k++) begin
                waitTig64(1'b1, "t6_tig_high");
                step(3);
                pufReady64 = 1'b1; pufResp64 = {1'b0, pat[k]};
                waitTig64(1'b0, "t6_tig_low");
                pufReady64 = 1'b0; pufResp64 = 2'b00;
            end
            n = 0;
            while (done64 !== 1'b1 && n < 60) begin
                step(1);
                n++;
            end
            chk("t6_done", done64, 1'b1);
            chk("t6_resp", resp64, 2'b01);
            chk("t6_timeout", timeout64, 1'b0);
            chk("t6_pulses", 128'(tigPulses64 - pulses0), 128'd5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
